// File: rtl/lin_neuron_array.sv
// rtl/lin_neuron_array.sv - time-multiplexed array of linear leaky-integrate neurons
// Purpose: NUM_CH neurons share one fixed-point update datapath; a step pulse
//   starts a sweep that updates one channel per clock (leak, integrate, threshold,
//   reset-on-spike, refractory hold) and publishes the spike vector at the end.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   cur_we/addr/data      write port of the per-channel input current file
//   dt, threshold         time step and spike threshold, captured on step accept
//   step                  start one sweep
//   busy                  sweep in progress
//   done                  one-cycle pulse at end of sweep
//   spike                 spike flags of the last completed sweep
//   overrun               sticky flag: step arrived while not idle
module lin_neuron_array #(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 16,
  parameter int DT_W         = 9,
  parameter int DT_SHIFT     = 8,
  parameter int LEAK_SHIFT   = 4,
  parameter int V_REST       = -65,
  parameter int V_RESET      = -70,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cur_we,
  input  logic [$clog2(NUM_CH)-1:0] cur_addr,
  input  logic signed [WIDTH-1:0]   cur_data,
  input  logic [DT_W-1:0]           dt,
  input  logic signed [WIDTH-1:0]   threshold,
  input  logic                      step,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_CH-1:0]         spike,
  output logic                      overrun
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int LW   = WIDTH + 1;
  localparam int DW   = WIDTH + 2;
  localparam int PW   = WIDTH + DT_W + 2;
  localparam int SW   = WIDTH + DT_W + 3;
  localparam int RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam logic signed [WIDTH-1:0] V_REST_W  = WIDTH'(V_REST);
  localparam logic signed [WIDTH-1:0] V_RESET_W = WIDTH'(V_RESET);
  localparam logic [CH_W-1:0]         LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [RC_W-1:0]         RC_LOAD   = RC_W'(REFRAC_STEPS);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t state, state_next;
  logic   accept;

  logic [CH_W-1:0]         ch;
  logic [DT_W-1:0]         dt_q;
  logic signed [WIDTH-1:0] thr_q;
  logic signed [WIDTH-1:0] v_mem    [NUM_CH];
  logic signed [WIDTH-1:0] cur_mem  [NUM_CH];
  logic [RC_W-1:0]         rcnt_mem [NUM_CH];
  logic [NUM_CH-1:0]       spike_sh;

  logic signed [WIDTH-1:0] v_cur;
  logic signed [LW-1:0]    vdiff;
  logic signed [LW-1:0]    leak;
  logic signed [DW-1:0]    diff;
  logic signed [PW-1:0]    prod;
  logic signed [SW-1:0]    sum;
  logic signed [WIDTH-1:0] v_sat;
  logic                    fire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (step) begin
          accept     = 1'b1;
          state_next = S_SWEEP;
        end
      end
      S_SWEEP: if (ch == LAST_CH) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state == S_SWEEP);

  // Shared update datapath for the channel selected by ch. The product is kept
  // at full width so only the final sum needs clamping.
  always_comb begin
    v_cur = v_mem[ch];
    vdiff = LW'(v_cur) - LW'(V_REST_W);
    leak  = vdiff >>> LEAK_SHIFT;
    diff  = DW'(cur_mem[ch]) - DW'(leak);
    prod  = PW'(diff) * PW'($signed({1'b0, dt_q}));
    sum   = SW'(v_cur) + SW'(prod >>> DT_SHIFT);
    // Fits in WIDTH bits only when all bits above the WIDTH sign bit agree.
    if (&sum[SW-1:WIDTH-1] || ~|sum[SW-1:WIDTH-1])
      v_sat = sum[WIDTH-1:0];
    else if (sum[SW-1])
      v_sat = {1'b1, {(WIDTH-1){1'b0}}};
    else
      v_sat = {1'b0, {(WIDTH-1){1'b1}}};
    fire = (v_sat >= thr_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        v_mem[k]    <= V_REST_W;
        cur_mem[k]  <= '0;
        rcnt_mem[k] <= '0;
      end
      ch       <= '0;
      dt_q     <= '0;
      thr_q    <= '0;
      spike_sh <= '0;
      spike    <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // The channel being processed reads the pre-edge register value, so a
      // write landing on the same edge only takes effect next sweep.
      if (cur_we && (int'(cur_addr) < NUM_CH))
        cur_mem[cur_addr] <= cur_data;

      if (accept) begin
        dt_q  <= dt;
        thr_q <= threshold;
        ch    <= '0;
      end else if (state == S_SWEEP) begin
        ch <= ch + CH_W'(1);
        if (rcnt_mem[ch] != '0) begin
          v_mem[ch]    <= V_RESET_W;
          rcnt_mem[ch] <= rcnt_mem[ch] - RC_W'(1);
          spike_sh[ch] <= 1'b0;
        end else if (fire) begin
          v_mem[ch]    <= V_RESET_W;
          rcnt_mem[ch] <= RC_LOAD;
          spike_sh[ch] <= 1'b1;
        end else begin
          v_mem[ch]    <= v_sat;
          spike_sh[ch] <= 1'b0;
        end
      end

      done <= (state == S_DONE);
      if (state == S_DONE) spike <= spike_sh;
      if (step && (state != S_IDLE)) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lin_neuron_array.sv
// tb/tb_lin_neuron_array.sv - directed self-checking bench for lin_neuron_array
module tb_lin_neuron_array;
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cur_we = 1'b0;
  logic [1:0]        cur_addr = '0;
  logic signed [15:0] cur_data = '0;
  logic [8:0]        dt = 9'd256;
  logic signed [15:0] threshold = 16'sd30;
  logic              step = 1'b0;
  logic              busy, done, overrun;
  logic [3:0]        spike;

  int checks = 0;
  int errors = 0;
  int bc, da, dc;

  lin_neuron_array dut (
    .clock(clock), .reset(reset), .cur_we(cur_we), .cur_addr(cur_addr),
    .cur_data(cur_data), .dt(dt), .threshold(threshold), .step(step),
    .busy(busy), .done(done), .spike(spike), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic write_cur(input logic [1:0] a, input logic signed [15:0] d);
    @(negedge clock);
    cur_we = 1'b1; cur_addr = a; cur_data = d;
    @(negedge clock) cur_we = 1'b0;
  endtask

  // Issues one step, then watches 12 edges (j = edges after accept edge t).
  // Optional events: second step sampled at edge t+xs, reset raised just after
  // edge t+ra, write of I1=1000 sampled at edge t+wa. -10 disables an event.
  task automatic sweep(input int xs, input int ra, input int wa,
                       output int nb, output int d_at, output int nd);
    nb = 0; d_at = -1; nd = 0;
    @(negedge clock) step = 1'b1;
    @(posedge clock); #1 step = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        if (d_at < 0) d_at = j;
      end
      if (j == xs - 1) step = 1'b1;
      if (j == xs) step = 1'b0;
      if (j == wa - 1) begin cur_we = 1'b1; cur_addr = 2'd1; cur_data = 16'sd1000; end
      if (j == wa) cur_we = 1'b0;
      if (j == ra) begin
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_spike", spike, 0);
        check("rst_mid_done", done, 0);
      end
      if (j == ra + 2) reset = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_spike", spike, 0);
    check("reset_overrun", overrun, 0);
    do_reset();

    // 1: idle neurons, timing
    sweep(-10, -10, -10, bc, da, dc);
    check("t1_busy_cycles", bc, 4);
    check("t1_done_at", da, 5);
    check("t1_done_count", dc, 1);
    check("t1_spike", spike, 0);
    for (int k = 0; k < 4; k++) check("t1_v", dut.v_mem[k], -65);

    // 2: spike then refractory hold
    do_reset();
    write_cur(2'd2, 16'sd1000);
    sweep(-10, -10, -10, bc, da, dc);
    check("t2_spike1", spike, 4'b0100);
    check("t2_v2", dut.v_mem[2], -70);
    check("t2_v0", dut.v_mem[0], -65);
    sweep(-10, -10, -10, bc, da, dc);
    check("t2_spike2", spike, 0);
    check("t2_v2_hold", dut.v_mem[2], -70);
    sweep(-10, -10, -10, bc, da, dc);
    check("t2_spike3", spike, 0);
    sweep(-10, -10, -10, bc, da, dc);
    check("t2_spike4", spike, 4'b0100);

    // 3: leak toward rest, threshold just above the sum
    do_reset();
    threshold = -16'sd32;
    write_cur(2'd0, 16'sd32);
    sweep(-10, -10, -10, bc, da, dc);
    check("t3_spike", spike, 0);
    check("t3_v0_a", dut.v_mem[0], -33);
    write_cur(2'd0, 16'sd0);
    sweep(-10, -10, -10, bc, da, dc);
    check("t3_v0_b", dut.v_mem[0], -35);
    sweep(-10, -10, -10, bc, da, dc);
    check("t3_v0_c", dut.v_mem[0], -36);
    sweep(-10, -10, -10, bc, da, dc);
    check("t3_v0_d", dut.v_mem[0], -37);

    // 3b: sum exactly equal to threshold fires
    do_reset();
    threshold = -16'sd33;
    write_cur(2'd0, 16'sd32);
    sweep(-10, -10, -10, bc, da, dc);
    check("t3b_spike_eq", spike, 4'b0001);
    check("t3b_v0", dut.v_mem[0], -70);

    // 4: saturation both ways
    do_reset();
    threshold = 16'sd32767;
    dt = 9'd511;
    write_cur(2'd1, 16'sd32767);
    write_cur(2'd3, -16'sd32768);
    sweep(-10, -10, -10, bc, da, dc);
    check("t4_spike", spike, 4'b0010);
    check("t4_v1", dut.v_mem[1], -70);
    check("t4_v3", dut.v_mem[3], -32768);
    check("t4_v0", dut.v_mem[0], -65);
    sweep(-10, -10, -10, bc, da, dc);
    check("t4_v3_again", dut.v_mem[3], -32768);
    threshold = 16'sd30;
    dt = 9'd256;

    // 4b: write landing on the edge that commits channel 1 is not seen
    do_reset();
    sweep(-10, -10, 2, bc, da, dc);
    check("t4b_spike_old", spike, 0);
    sweep(-10, -10, -10, bc, da, dc);
    check("t4b_spike_new", spike, 4'b0010);

    // 5: overrun
    do_reset();
    check("t5_overrun_clr", overrun, 0);
    sweep(2, -10, -10, bc, da, dc);
    check("t5_done_count", dc, 1);
    check("t5_busy_cycles", bc, 4);
    check("t5_done_at", da, 5);
    check("t5_overrun", overrun, 1);
    sweep(-10, -10, -10, bc, da, dc);
    check("t5_overrun_sticky", overrun, 1);
    do_reset();
    check("t5_overrun_reset", overrun, 0);

    // 6: reset mid-sweep
    write_cur(2'd2, 16'sd1000);
    sweep(-10, -10, -10, bc, da, dc);
    check("t6_spike_pre", spike, 4'b0100);
    sweep(-10, 2, -10, bc, da, dc);
    check("t6_no_done", dc, 0);
    check("t6_v2", dut.v_mem[2], -65);
    sweep(-10, -10, -10, bc, da, dc);
    check("t6_done_at", da, 5);
    check("t6_spike_post", spike, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
